// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Reads a burst of burst_len words from a synchronous FIFO and replays them
//   on a valid/ready output stream through a 2-entry skid buffer. Reads are
//   throttled so that buffered plus in-flight words never exceed two, which
//   keeps full throughput when m_ready=1 and never overflows the buffer.
//
//   Optional feature: define FIFO_BURST_READER_TIMEOUT_EN to abort a burst
//   after TIMEOUT consecutive FIFO-empty cycles in RUN. Without the macro the
//   block waits for data indefinitely and timeout is tied low.
//
// Ports
//   clk         clock, all state on rising edge
//   rst         asynchronous active-low reset
//   start       burst request, sampled only in IDLE
//   burst_len   word count, latched with start (0 = empty burst, done only)
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  FIFO read strobe
//   m_valid     output word valid
//   m_data      output word (oldest buffered)
//   m_ready     downstream accept
//   busy        high outside IDLE
//   done        one-cycle pulse at burst completion
//   timeout     one-cycle pulse with done when the burst was aborted
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads until remaining reaches 0 (or abort)
// FLUSH | no more reads; draining in-flight and buffered words

module fifo_burst_reader #(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [1:0]       occ;
    logic             inflight;
    logic [WIDTH-1:0] buf0, buf1;
    logic             pop;
    logic [2:0]       occ_proj;
    logic             abort;
    logic             aborted;
    logic             done_nxt, timeout_nxt;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf0;
    assign busy    = (state != S_IDLE);
    assign pop     = m_valid && m_ready;

    // Occupancy the buffer will have once the word already in flight lands,
    // net of this cycle's pop. A new read is only safe while this is below 2.
    assign occ_proj = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = (state == S_RUN) && (remaining != '0) && !fifo_empty
                        && (occ_proj < 3'd2);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] empty_cnt;
    logic          stall_empty;

    assign stall_empty = (state == S_RUN) && (remaining != '0) && fifo_empty;
    assign abort       = stall_empty && (empty_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            empty_cnt <= '0;
        end else if (stall_empty) begin
            empty_cnt <= empty_cnt + TW'(1);
        end else begin
            empty_cnt <= '0;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        timeout_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_nxt     = S_RUN;
                        remaining_nxt = burst_len;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (fifo_rd_en) begin
                    remaining_nxt = remaining - LEN_W'(1);
                end
                if (abort) begin
                    state_nxt     = S_FLUSH;
                    remaining_nxt = '0;
                end else if (fifo_rd_en && (remaining == LEN_W'(1))) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Leave on the edge that empties the buffer so done lands
                // in the cycle right after the last word is accepted.
                if (!inflight && (occ_proj == 3'd0)) begin
                    state_nxt   = S_IDLE;
                    done_nxt    = 1'b1;
                    timeout_nxt = aborted;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            done      <= done_nxt;
            timeout   <= timeout_nxt;
            aborted   <= (state == S_IDLE) ? 1'b0 : (aborted | abort);
        end
    end

    // Output buffer: buf0 is always the oldest word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf1 <= fifo_rdata;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= fifo_rdata;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
    localparam int WIDTH = 8;
    localparam int LEN_W = 8;
    localparam int TMO   = 8;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             start      = 1'b0;
    logic [LEN_W-1:0] burst_len  = '0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready    = 1'b0;
    logic             busy;
    logic             done;
    logic             timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // FIFO contents and the words the stream must deliver, in order
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] fifo_w;
    logic [WIDTH-1:0] exp_w;
    logic             rd_en_s = 1'b0;

    int rd_count   = 0;
    int pop_count  = 0;
    int first_pop  = 0;
    int last_pop   = 0;
    int burst_left = 0;
    bit zero_req   = 1'b0;
    bit done_due   = 1'b0;
    bit prev_stall = 1'b0;
    bit check_done = 1'b1;
    bit tmo_allowed = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    int c0;
    int dc;

    fifo_burst_reader #(
        .WIDTH  (WIDTH),
        .LEN_W  (LEN_W),
        .TIMEOUT(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w, input bit expect_it);
        fifo_q.push_back(w);
        if (expect_it) exp_q.push_back(w);
    endtask

    task automatic start_burst(input int len, output int cs);
        cs         = cyc;
        burst_len  = LEN_W'(len);
        start      = 1'b1;
        burst_left = len;
        zero_req   = (len == 0);
        tick(1);
        start      = 1'b0;
        burst_len  = '0;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick(1);
        end
        if (dcyc < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done actual=no_done required=done_within_%0d", limit);
        end
    endtask

    // Synchronous FIFO model: read data registered, empty flag registered
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (rd_en_s && (fifo_q.size() != 0)) begin
            fifo_w = fifo_q.pop_front();
            fifo_rdata <= fifo_w;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Per-cycle compare against the stream model
    initial forever begin
        @(negedge clk);
        rd_en_s = fifo_rd_en;
        if (!rst) begin
            prev_stall = 1'b0;
            done_due   = 1'b0;
        end else begin
            if (fifo_rd_en) rd_count++;
            chk("no_read_when_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
            if (prev_stall) begin
                chk("stall_valid_held", {31'd0, m_valid}, 32'd1);
                chk("stall_data_held", {24'd0, m_data}, {24'd0, prev_data});
            end
            if (check_done) chk("done_model", {31'd0, done}, {31'd0, done_due});
            if (!tmo_allowed) chk("timeout_low", {31'd0, timeout}, 32'd0);
            done_due = zero_req;
            zero_req = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", m_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("stream_order", {24'd0, m_data}, {24'd0, exp_w});
                end
                if (pop_count == 0) first_pop = cyc;
                pop_count++;
                last_pop = cyc;
                if (burst_left > 0) begin
                    burst_left--;
                    if (burst_left == 0) done_due = 1'b1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset values, asynchronously and before any clock edge
        #1 rst = 1'b0;
        #1;
        chk("rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data",  {24'd0, m_data}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_done",    {31'd0, done}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Four words back to back, full throughput
        m_ready = 1'b1;
        pop_count = 0;
        rd_count  = 0;
        for (int i = 0; i < 4; i++) push_word(WIDTH'(8'h11 + i), 1'b1);
        start_burst(4, c0);
        wait_done(40, dc);
        chk("t1_words",       pop_count, 32'd4);
        chk("t1_first_lat",   first_pop - c0, 32'd3);
        chk("t1_last_word",   last_pop - c0, 32'd6);
        chk("t1_done_cycle",  dc - c0, 32'd7);
        chk("t1_reads",       rd_count, 32'd4);
        chk("t1_busy_done",   {31'd0, busy}, 32'd0);
        chk("t1_all_out",     exp_q.size(), 32'd0);
        tick(2);

        // Downstream stalled for 10 cycles: two reads only, first word held
        m_ready   = 1'b0;
        pop_count = 0;
        rd_count  = 0;
        push_word(8'hA1, 1'b1);
        push_word(8'hA2, 1'b1);
        push_word(8'hA3, 1'b1);
        start_burst(3, c0);
        tick(9);
        chk("t2_stall_reads", rd_count, 32'd2);
        chk("t2_valid",       {31'd0, m_valid}, 32'd1);
        chk("t2_data_first",  {24'd0, m_data}, 32'hA1);
        chk("t2_no_pops",     pop_count, 32'd0);
        m_ready = 1'b1;
        wait_done(40, dc);
        chk("t2_words",       pop_count, 32'd3);
        chk("t2_all_out",     exp_q.size(), 32'd0);
        tick(2);

        // Zero-length burst
        rd_count = 0;
        push_word(8'h55, 1'b0);
        start_burst(0, c0);
        chk("t3_done",      {31'd0, done}, 32'd1);
        chk("t3_busy",      {31'd0, busy}, 32'd0);
        tick(1);
        chk("t3_done_once", {31'd0, done}, 32'd0);
        chk("t3_busy_after",{31'd0, busy}, 32'd0);
        tick(3);
        chk("t3_no_reads",  rd_count, 32'd0);
        fifo_q.delete();
        tick(2);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
        // FIFO runs dry after 2 of 5 words: burst is aborted
        check_done  = 1'b0;
        tmo_allowed = 1'b1;
        pop_count   = 0;
        rd_count    = 0;
        push_word(8'h21, 1'b1);
        push_word(8'h22, 1'b1);
        start_burst(5, c0);
        wait_done(80, dc);
        chk("t4_timeout_with_done", {31'd0, timeout}, 32'd1);
        chk("t4_idle",     {31'd0, busy}, 32'd0);
        chk("t4_words",    pop_count, 32'd2);
        chk("t4_reads",    rd_count, 32'd2);
        chk("t4_abort_window", {31'd0, ((dc - c0) >= TMO + 3) && ((dc - c0) <= TMO + 5)}, 32'd1);
        tick(1);
        chk("t4_timeout_once", {31'd0, timeout}, 32'd0);
        chk("t4_done_once",    {31'd0, done}, 32'd0);
        check_done  = 1'b1;
        tmo_allowed = 1'b0;
`else
        // FIFO runs dry after 2 of 5 words, refilled 20 cycles later
        pop_count = 0;
        rd_count  = 0;
        push_word(8'h21, 1'b1);
        push_word(8'h22, 1'b1);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h25);
        start_burst(5, c0);
        tick(20);
        chk("t4_waiting", {31'd0, busy}, 32'd1);
        chk("t4_partial", pop_count, 32'd2);
        push_word(8'h23, 1'b0);
        push_word(8'h24, 1'b0);
        push_word(8'h25, 1'b0);
        wait_done(60, dc);
        chk("t4_words",    pop_count, 32'd5);
        chk("t4_reads",    rd_count, 32'd5);
        chk("t4_all_out",  exp_q.size(), 32'd0);
        chk("t4_no_timeout", {31'd0, timeout}, 32'd0);
`endif
        tick(2);

        // Reset with two words buffered, then restart on the first edge
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(WIDTH'(8'h31 + i), 1'b0);
        start_burst(4, c0);
        tick(4);
        chk("t5_pre_valid", {31'd0, m_valid}, 32'd1);
        chk("t5_pre_data",  {24'd0, m_data}, 32'h31);
        check_done = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t5_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        chk("t5_m_valid", {31'd0, m_valid}, 32'd0);
        chk("t5_m_data",  {24'd0, m_data}, 32'd0);
        chk("t5_busy",    {31'd0, busy}, 32'd0);
        chk("t5_done",    {31'd0, done}, 32'd0);
        chk("t5_timeout", {31'd0, timeout}, 32'd0);
        tick(2);
        check_done = 1'b1;
        rst        = 1'b1;
        // The FIFO was not drained: the next burst reads the two left over
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h34);
        pop_count = 0;
        m_ready   = 1'b1;
        start_burst(2, c0);
        chk("t5_first_start", {31'd0, busy}, 32'd1);
        wait_done(40, dc);
        chk("t5_words",      pop_count, 32'd2);
        chk("t5_done_cycle", dc - c0, 32'd5);
        chk("t5_all_out",    exp_q.size(), 32'd0);
        tick(2);

        // Intermittent ready: order and done timing under mixed push/pop
        pop_count = 0;
        rd_count  = 0;
        for (int i = 0; i < 6; i++) push_word(WIDTH'(8'h40 + i), 1'b1);
        start_burst(6, c0);
        for (int i = 0; i < 8; i++) begin
            m_ready = ((i % 3) != 2);
            tick(1);
        end
        m_ready = 1'b1;
        wait_done(40, dc);
        chk("t6_words",   pop_count, 32'd6);
        chk("t6_reads",   rd_count, 32'd6);
        chk("t6_all_out", exp_q.size(), 32'd0);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
